// File: rtl/motor_pwm_ctrl_if.sv
// Sensor inputs and H-bridge leg outputs of the line-follower motor controller.
// The controller is the slave; whoever drives the sensors is the master.
interface motor_pwm_ctrl_if;
  logic       E;
  logic       D;
  logic       F;
  logic       Liga;
  logic       Re;
  logic       R_Re;
  logic       Rd;
  logic       R_Rd;
  logic [1:0] st_e;
  logic [1:0] st_d;

  modport master (
    output E, D, F, Liga,
    input  Re, R_Re, Rd, R_Rd, st_e, st_d
  );

  modport slave (
    input  E, D, F, Liga,
    output Re, R_Re, Rd, R_Rd, st_e, st_d
  );
endinterface

// File: rtl/motor_pwm_ctrl.sv
// Two-side H-bridge controller: sensor decode, per-side STOP/FWD/REV/DEAD FSM,
// soft-start duty ramp and a shared PWM counter. Index 0 is the left (E) side, 1 the right (D) side.
module motor_pwm_ctrl #(
  parameter int PWM_W     = 8,
  parameter int DUTY_MAX  = 200,
  parameter int RAMP_STEP = 8,
  parameter int RAMP_DIV  = 1024,
  parameter int DEADTIME  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  motor_pwm_ctrl_if.slave  io
);

  localparam int PW = $clog2(RAMP_DIV);
  localparam int DW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_FWD  = 2'd1,
    ST_REV  = 2'd2,
    ST_DEAD = 2'd3
  } state_e;

  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tick;
  state_e           cmd     [2];
  state_e           st_q    [2];
  state_e           st_d    [2];
  logic [PWM_W-1:0] duty_q  [2];
  logic [PWM_W-1:0] duty_d  [2];
  logic [DW-1:0]    dead_q  [2];
  logic [DW-1:0]    dead_d  [2];
  logic [1:0]       fwd_q, fwd_d;
  logic [1:0]       rev_q, rev_d;

  function automatic logic [PWM_W-1:0] ramp_up(input logic [PWM_W-1:0] duty);
    int sum;
    sum = int'(duty) + RAMP_STEP;
    if (sum >= DUTY_MAX) return PWM_W'(DUTY_MAX);
    return PWM_W'(sum);
  endfunction

  // Synchronised inputs packed as {E, D, F, Liga}.
  always_comb begin
    sync1_d   = {io.E, io.D, io.F, io.Liga};
    sync2_d   = sync1_q;
    pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
    tick      = (presc_q == PW'(RAMP_DIV - 1));
    presc_d   = tick ? '0 : presc_q + PW'(1);
  end

  always_comb begin
    cmd[0] = ST_STOP;
    cmd[1] = ST_STOP;
    if (sync2_q[0]) begin
      case (sync2_q[3:2])
        2'b00: begin
          cmd[0] = sync2_q[1] ? ST_REV : ST_FWD;
          cmd[1] = sync2_q[1] ? ST_REV : ST_FWD;
        end
        2'b01: begin
          cmd[0] = ST_REV;
          cmd[1] = ST_FWD;
        end
        2'b10: begin
          cmd[0] = ST_FWD;
          cmd[1] = ST_REV;
        end
        default: begin
          cmd[0] = ST_STOP;
          cmd[1] = ST_STOP;
        end
      endcase
    end
  end

  // Legs are derived from next state/duty/counter so they line up with st_q after the edge.
  always_comb begin
    fwd_d = '0;
    rev_d = '0;
    for (int s = 0; s < 2; s++) begin
      st_d[s]   = st_q[s];
      duty_d[s] = duty_q[s];
      dead_d[s] = dead_q[s];
      case (st_q[s])
        ST_STOP: begin
          if (cmd[s] != ST_STOP) begin
            st_d[s]   = cmd[s];
            duty_d[s] = '0;
          end
        end
        ST_FWD, ST_REV: begin
          if (cmd[s] != st_q[s]) begin
            st_d[s]   = ST_DEAD;
            duty_d[s] = '0;
            dead_d[s] = DW'(DEADTIME - 1);
          end else if (tick) begin
            duty_d[s] = ramp_up(duty_q[s]);
          end
        end
        default: begin
          if (dead_q[s] == '0) begin
            st_d[s]   = cmd[s];
            duty_d[s] = '0;
          end else begin
            dead_d[s] = dead_q[s] - DW'(1);
          end
        end
      endcase
      fwd_d[s] = (st_d[s] == ST_FWD) && (pwm_cnt_d < duty_d[s]);
      rev_d[s] = (st_d[s] == ST_REV) && (pwm_cnt_d < duty_d[s]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      pwm_cnt_q <= '0;
      presc_q   <= '0;
      fwd_q     <= '0;
      rev_q     <= '0;
      for (int s = 0; s < 2; s++) begin
        st_q[s]   <= ST_STOP;
        duty_q[s] <= '0;
        dead_q[s] <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      pwm_cnt_q <= pwm_cnt_d;
      presc_q   <= presc_d;
      fwd_q     <= fwd_d;
      rev_q     <= rev_d;
      for (int s = 0; s < 2; s++) begin
        st_q[s]   <= st_d[s];
        duty_q[s] <= duty_d[s];
        dead_q[s] <= dead_d[s];
      end
    end
  end

  assign io.Re   = fwd_q[0];
  assign io.R_Re = rev_q[0];
  assign io.Rd   = fwd_q[1];
  assign io.R_Rd = rev_q[1];
  assign io.st_e = st_q[0];
  assign io.st_d = st_q[1];

endmodule
